// File: rtl/knn_topk_selector.sv
// Top-K nearest-neighbour selector: keeps the K smallest (distance, index) pairs
// with a one-cycle parallel insertion sort, then streams them in rank order.
module knn_topk_selector #(
  parameter int dataWidth  = 32,
  parameter int indexWidth = 16,
  parameter int K          = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [dataWidth-1:0]  distance,
  input  logic                  distanceValid,
  input  logic                  done,
  input  logic                  start,
  output logic [dataWidth-1:0]  out_distance,
  output logic [indexWidth-1:0] out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow,
  output logic                  overrun
);

  localparam int RW = $clog2(K + 1);

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    WAIT_LAST = 2'd1,
    DRAIN     = 2'd2,
    FINISHED  = 2'd3
  } state_t;

  state_t                state_r, state_next_s;
  logic                  busy_r;
  logic [K-1:0]          slot_vld_r;
  logic [dataWidth-1:0]  slot_dist_r [K];
  logic [indexWidth-1:0] slot_idx_r  [K];
  logic [indexWidth-1:0] idx_r;
  logic                  overflow_r, overrun_r;
  logic [dataWidth-1:0]  out_dist_r;
  logic [indexWidth-1:0] out_idx_r;
  logic                  out_valid_r, out_last_r;
  logic [RW-1:0]         rank_r;

  logic [K-1:0]          lt_s, prev_lt_s;
  logic [K-1:0]          src_vld_s, ins_vld_s;
  logic [dataWidth-1:0]  src_dist_s [K];
  logic [dataWidth-1:0]  ins_dist_s [K];
  logic [indexWidth-1:0] src_idx_s  [K];
  logic [indexWidth-1:0] ins_idx_s  [K];
  logic [K:0]            vld_pad_s;
  logic [RW-1:0]         nxt_rank_s, nxt_plus_s;
  logic [dataWidth-1:0]  beat_dist_s;
  logic [indexWidth-1:0] beat_idx_s;
  logic                  beat_last_s;
  logic                  accept_s, clear_s, load_beat_s, drop_beat_s, overrun_s;

  // Parallel insertion: slot i takes the new entry at the insertion point, its
  // upper neighbour below it, or keeps its own. Equal distances do not displace.
  always_comb begin
    lt_s       = {K{1'b0}};
    src_vld_s  = {K{1'b0}};
    ins_vld_s  = {K{1'b0}};
    for (int i = 0; i < K; i++) begin
      src_dist_s[i] = {dataWidth{1'b0}};
      src_idx_s[i]  = {indexWidth{1'b0}};
      ins_dist_s[i] = {dataWidth{1'b0}};
      ins_idx_s[i]  = {indexWidth{1'b0}};
      lt_s[i]       = !slot_vld_r[i] || (distance < slot_dist_r[i]);
    end
    for (int i = 1; i < K; i++) begin
      src_vld_s[i]  = slot_vld_r[i-1];
      src_dist_s[i] = slot_dist_r[i-1];
      src_idx_s[i]  = slot_idx_r[i-1];
    end
    prev_lt_s = lt_s << 1;
    for (int i = 0; i < K; i++) begin
      if (!lt_s[i]) begin
        ins_vld_s[i]  = slot_vld_r[i];
        ins_dist_s[i] = slot_dist_r[i];
        ins_idx_s[i]  = slot_idx_r[i];
      end else if (!prev_lt_s[i]) begin
        ins_vld_s[i]  = 1'b1;
        ins_dist_s[i] = distance;
        ins_idx_s[i]  = idx_r;
      end else begin
        ins_vld_s[i]  = src_vld_s[i];
        ins_dist_s[i] = src_dist_s[i];
        ins_idx_s[i]  = src_idx_s[i];
      end
    end
  end

  // Next output beat: rank 0 when the stream starts, otherwise the following rank.
  always_comb begin
    vld_pad_s   = {1'b0, slot_vld_r};
    nxt_rank_s  = out_valid_r ? (rank_r + RW'(1'b1)) : {RW{1'b0}};
    nxt_plus_s  = nxt_rank_s + RW'(1'b1);
    beat_dist_s = {dataWidth{1'b0}};
    beat_idx_s  = {indexWidth{1'b0}};
    beat_last_s = 1'b1;
    for (int i = 0; i < K; i++) begin
      beat_dist_s = (nxt_rank_s == RW'(i)) ? slot_dist_r[i] : beat_dist_s;
      beat_idx_s  = (nxt_rank_s == RW'(i)) ? slot_idx_r[i]  : beat_idx_s;
    end
    for (int i = 0; i <= K; i++) begin
      beat_last_s = (nxt_plus_s == RW'(i)) ? !vld_pad_s[i] : beat_last_s;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    clear_s      = 1'b0;
    load_beat_s  = 1'b0;
    drop_beat_s  = 1'b0;
    overrun_s    = 1'b0;
    case (state_r)
      COLLECT: begin
        accept_s = distanceValid;
        if (done && distanceValid) begin
          state_next_s = DRAIN;
        end else if (done) begin
          state_next_s = WAIT_LAST;
        end else begin
          state_next_s = COLLECT;
        end
      end
      WAIT_LAST: begin
        accept_s = distanceValid;
        if (distanceValid) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = WAIT_LAST;
        end
      end
      DRAIN: begin
        overrun_s = distanceValid;
        if (!out_valid_r) begin
          if (slot_vld_r[0]) begin
            load_beat_s = 1'b1;
          end else begin
            state_next_s = FINISHED;
          end
        end else if (out_ready) begin
          if (out_last_r) begin
            drop_beat_s  = 1'b1;
            state_next_s = FINISHED;
          end else begin
            load_beat_s = 1'b1;
          end
        end else begin
          state_next_s = DRAIN;
        end
      end
      FINISHED: begin
        overrun_s = distanceValid;
        if (start) begin
          clear_s      = 1'b1;
          state_next_s = COLLECT;
        end else begin
          state_next_s = FINISHED;
        end
      end
      default: begin
        state_next_s = COLLECT;
      end
    endcase
  end

  // State register and busy flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= COLLECT;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != FINISHED);
    end
  end

  // Sorted list storage, sample counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_vld_r <= {K{1'b0}};
      for (int i = 0; i < K; i++) begin
        slot_dist_r[i] <= {dataWidth{1'b0}};
        slot_idx_r[i]  <= {indexWidth{1'b0}};
      end
      idx_r      <= {indexWidth{1'b0}};
      overflow_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (clear_s) begin
        slot_vld_r <= {K{1'b0}};
        idx_r      <= {indexWidth{1'b0}};
      end else if (accept_s) begin
        slot_vld_r <= ins_vld_s;
        for (int i = 0; i < K; i++) begin
          slot_dist_r[i] <= ins_dist_s[i];
          slot_idx_r[i]  <= ins_idx_s[i];
        end
        idx_r <= idx_r + indexWidth'(1'b1);
        if (&idx_r) begin
          overflow_r <= 1'b1;
        end
      end
      if (overrun_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Output beat register; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_dist_r  <= {dataWidth{1'b0}};
      out_idx_r   <= {indexWidth{1'b0}};
      rank_r      <= {RW{1'b0}};
    end else if (load_beat_s) begin
      out_valid_r <= 1'b1;
      out_last_r  <= beat_last_s;
      out_dist_r  <= beat_dist_s;
      out_idx_r   <= beat_idx_s;
      rank_r      <= nxt_rank_s;
    end else if (drop_beat_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  assign out_distance = out_dist_r;
  assign out_index    = out_idx_r;
  assign out_valid    = out_valid_r;
  assign out_last     = out_last_r;
  assign busy         = busy_r;
  assign overflow     = overflow_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_knn_topk_selector.sv
// Directed bench for knn_topk_selector: instance A (K=4, 16-bit index) and
// instance B (K=4, 4-bit index) share stimulus; B is observed for counter wrap.
module tb_knn_topk_selector;

  logic        clk, resetn, distanceValid, done, start, out_ready;
  logic [31:0] distance;

  logic [31:0] a_out_distance, b_out_distance;
  logic [15:0] a_out_index;
  logic [3:0]  b_out_index;
  logic a_out_valid, a_out_last, a_busy, a_overflow, a_overrun;
  logic b_out_valid, b_out_last, b_busy, b_overflow, b_overrun;

  logic        use_b;
  logic [31:0] obs_distance;
  logic [15:0] obs_index;
  logic        obs_valid, obs_last, obs_busy;

  int n_checks, n_pass;
  logic [31:0] exp_d [8];
  logic [15:0] exp_i [8];

  knn_topk_selector #(.dataWidth(32), .indexWidth(16), .K(4)) dut_a (
    .clk(clk), .resetn(resetn), .distance(distance), .distanceValid(distanceValid),
    .done(done), .start(start), .out_distance(a_out_distance), .out_index(a_out_index),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_last(a_out_last),
    .busy(a_busy), .overflow(a_overflow), .overrun(a_overrun)
  );

  knn_topk_selector #(.dataWidth(32), .indexWidth(4), .K(4)) dut_b (
    .clk(clk), .resetn(resetn), .distance(distance), .distanceValid(distanceValid),
    .done(done), .start(start), .out_distance(b_out_distance), .out_index(b_out_index),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_last(b_out_last),
    .busy(b_busy), .overflow(b_overflow), .overrun(b_overrun)
  );

  assign obs_distance = use_b ? b_out_distance : a_out_distance;
  assign obs_index    = use_b ? {12'd0, b_out_index} : a_out_index;
  assign obs_valid    = use_b ? b_out_valid : a_out_valid;
  assign obs_last     = use_b ? b_out_last : a_out_last;
  assign obs_busy     = use_b ? b_busy : a_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic dn);
    distance      = d;
    distanceValid = 1'b1;
    done          = dn;
    tick();
    distanceValid = 1'b0;
    done          = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_exp(input int k, input logic [31:0] d, input logic [15:0] i);
    exp_d[k] = d;
    exp_i[k] = i;
  endtask

  // Drain with a repeating 4-cycle ready pattern; checks order, last flag and hold.
  task automatic drain_check(input string tag, input int n, input logic [3:0] pat);
    int k;
    logic held;
    logic [47:0] held_val;
    k = 0;
    held = 1'b0;
    held_val = 48'd0;
    for (int c = 0; c < 40; c++) begin
      out_ready = pat[c % 4];
      if (obs_valid) begin
        if (held) check({tag, "_hold"}, {obs_distance, obs_index}, held_val);
        if (out_ready) begin
          if (k < n) begin
            check({tag, "_dist"}, obs_distance, exp_d[k]);
            check({tag, "_idx"}, obs_index, exp_i[k]);
            check({tag, "_last"}, obs_last, (k == n - 1));
          end
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_val = {obs_distance, obs_index};
        end
      end else if (!obs_busy) begin
        break;
      end
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_beats"}, k, n);
    check({tag, "_busy_end"}, obs_busy, 1'b0);
    check({tag, "_valid_end"}, obs_valid, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    use_b = 1'b0;
    resetn = 1'b0;
    distance = 32'd0;
    distanceValid = 1'b0;
    done = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_last", a_out_last, 1'b0);
    check("rst_dist", a_out_distance, 32'd0);
    check("rst_idx", a_out_index, 16'd0);
    check("rst_busy", a_busy, 1'b1);
    check("rst_flags", {a_overflow, a_overrun}, 2'b00);
    resetn = 1'b1;

    // 1: sort with a tie, full list, last sample arrives with done
    send(32'd9, 1'b0); send(32'd3, 1'b0); send(32'd7, 1'b0); send(32'd3, 1'b0);
    send(32'd1, 1'b1);
    set_exp(0, 32'd1, 16'd4); set_exp(1, 32'd3, 16'd1);
    set_exp(2, 32'd3, 16'd3); set_exp(3, 32'd7, 16'd2);
    drain_check("t1", 4, 4'b1111);

    // 2: partial list, done alone then one trailing sample
    pulse_start();
    check("t2_busy_start", a_busy, 1'b1);
    send(32'd5, 1'b0); send(32'd2, 1'b0);
    done = 1'b1; tick(); done = 1'b0;
    check("t2_wait_busy", a_busy, 1'b1);
    check("t2_wait_valid", a_out_valid, 1'b0);
    send(32'd4, 1'b0);
    set_exp(0, 32'd2, 16'd1); set_exp(1, 32'd4, 16'd2); set_exp(2, 32'd5, 16'd0);
    drain_check("t2", 3, 4'b1111);

    // 3: backpressure 1,0,0,1
    pulse_start();
    send(32'd6, 1'b0); send(32'd2, 1'b0); send(32'd8, 1'b1);
    set_exp(0, 32'd2, 16'd1); set_exp(1, 32'd6, 16'd0); set_exp(2, 32'd8, 16'd2);
    drain_check("t3", 3, 4'b1001);

    // 4: reset after one beat
    pulse_start();
    send(32'd5, 1'b0); send(32'd6, 1'b0); send(32'd7, 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && !a_out_valid; c++) tick();
    check("t4_first", {a_out_valid, a_out_distance, a_out_index}, {1'b1, 32'd5, 16'd0});
    tick();
    check("t4_second", {a_out_distance, a_out_index}, {32'd6, 16'd1});
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    out_ready = 1'b0;
    check("t4_rst_valid", a_out_valid, 1'b0);
    check("t4_rst_busy", a_busy, 1'b1);
    tick();
    check("t4_no_beat", a_out_valid, 1'b0);
    send(32'd30, 1'b0); send(32'd10, 1'b0); send(32'd20, 1'b1);
    set_exp(0, 32'd10, 16'd1); set_exp(1, 32'd20, 16'd2); set_exp(2, 32'd30, 16'd0);
    drain_check("t4_rerun", 3, 4'b1111);

    // 5: index wrap on the narrow instance, then overrun in FINISHED
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int j = 0; j < 16; j++) send(32'(100 - j), 1'b0);
    send(32'd84, 1'b1);
    check("t5_overflow_b", b_overflow, 1'b1);
    check("t5_overflow_a", a_overflow, 1'b0);
    use_b = 1'b1;
    set_exp(0, 32'd84, 16'd0); set_exp(1, 32'd85, 16'd15);
    set_exp(2, 32'd86, 16'd14); set_exp(3, 32'd87, 16'd13);
    drain_check("t5", 4, 4'b1111);
    use_b = 1'b0;
    check("t5_overrun_pre", b_overrun, 1'b0);
    send(32'd50, 1'b0);
    tick();
    check("t5_overrun_b", b_overrun, 1'b1);
    check("t5_overrun_a", a_overrun, 1'b1);
    check("t5_idle", {b_busy, b_out_valid}, 2'b00);

    // 6: done with no samples, then a single all-ones distance
    pulse_start();
    done = 1'b1; tick(); done = 1'b0;
    send(32'hFFFF_FFFF, 1'b0);
    set_exp(0, 32'hFFFF_FFFF, 16'd0);
    drain_check("t6", 1, 4'b1111);
    check("t6_overrun_sticky", a_overrun, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
